// File: rtl/mem_pkg.sv
// Shared types and defaults for the SRAM-backed memory stage.
//   mem_state_e : access FSM states (IDLE, LO, HI, DONE)
//   BASE_ADDR_DEF / SRAM_AW_DEF : default byte base and SRAM half-word address width
//   LO_HALF / HI_HALF : half-word select bit appended to the word address
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned SRAM_AW_DEF   = 18;

  localparam logic LO_HALF = 1'b0;
  localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/sram_ctrl.sv
// Two-phase (low half, high half) access sequencer for a 16-bit async SRAM.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, we       : begin an access (sampled only in IDLE); 1 = write
//   word_addr       : 32-bit word index; halves live at {word_addr, 0/1}
//   wdata / rdata   : 32-bit write data / registered read data
//   idle, done      : FSM is in IDLE / in the single DONE cycle
//   sram_*          : SRAM address, write data, drive enable, write strobe, read data
module sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               we,
  input  logic [SRAM_AW-2:0] word_addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               idle,
  output logic               done,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES - 1);

  mem_state_e  state_q, state_d, phase;
  logic [2:0]  cnt_q, cnt_d, phase_cnt;
  logic [31:0] rdata_q, rdata_d;
  logic        go;
  logic        last;
  logic        active;
  logic        half;

  // The cycle in which a request is accepted is already the first LO bus
  // cycle, so the stall is exactly 2*WAIT_CYCLES. rst also gates the
  // acceptance so a held store cannot pull the write strobe low during reset.
  always_comb begin
    go        = start & ~rst & (state_q == IDLE);
    phase     = state_q;
    phase_cnt = cnt_q;
    if (go) begin
      phase     = LO;
      phase_cnt = '0;
    end
    last = (phase_cnt == LAST_CNT);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (phase)
      IDLE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      LO: begin
        if (last) begin
          state_d = HI;
          cnt_d   = '0;
        end else begin
          state_d = LO;
          cnt_d   = phase_cnt + 3'd1;
        end
      end
      HI: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          state_d = HI;
          cnt_d   = phase_cnt + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: SRAM pins and read-data capture
  always_comb begin
    active     = (phase == LO) || (phase == HI);
    half       = (phase == HI) ? HI_HALF : LO_HALF;
    sram_addr  = '0;
    sram_dq_o  = '0;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    rdata_d    = rdata_q;
    if (active) begin
      sram_addr = {word_addr, half};
      if (we) begin
        sram_dq_o  = (half == HI_HALF) ? wdata[31:16] : wdata[15:0];
        sram_dq_oe = 1'b1;
        // Strobe released in the final cycle so address/data are held past the rising edge.
        sram_we_n  = last;
      end else if (last) begin
        if (half == HI_HALF) rdata_d[31:16] = sram_dq_i;
        else                 rdata_d[15:0]  = sram_dq_i;
      end
    end
  end

  assign rdata = rdata_q;
  assign idle  = (state_q == IDLE);
  assign done  = (state_q == DONE);

endmodule

// File: rtl/mem_stage_sram.sv
// Pipeline memory stage backed by an external 16-bit asynchronous SRAM.
// Each 32-bit word takes two half-word accesses; ready = 0 freezes the pipeline.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, ALU_res_in, Val_Rm_in, Dest_in : from EX/MEM
//   WB_EN_out, MEM_R_EN_out, ALU_res_out, mem_out, Dest_out            : to MEM/WB
//   ready                            : 0 = freeze the pipeline
//   sram_addr, sram_dq_o, sram_dq_i, sram_dq_oe, sram_we_n : SRAM pins
// Build option: define MEM_WRITE_BUFFER_EN for a one-entry posted-write buffer.
module mem_stage_sram
  import mem_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_EN_in,
  input  logic               MEM_R_EN_in,
  input  logic               MEM_W_EN_in,
  input  logic [31:0]        ALU_res_in,
  input  logic [31:0]        Val_Rm_in,
  input  logic [3:0]         Dest_in,
  output logic               WB_EN_out,
  output logic               MEM_R_EN_out,
  output logic [31:0]        ALU_res_out,
  output logic [31:0]        mem_out,
  output logic [3:0]         Dest_out,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  logic [31:0]        offset;
  logic [SRAM_AW-2:0] in_word;
  logic               is_load, is_store, mem_req;
  logic               ctrl_start, ctrl_we, ctrl_idle, ctrl_done;
  logic [SRAM_AW-2:0] ctrl_word;
  logic [31:0]        ctrl_wdata;

  // Addresses below BASE_ADDR wrap modulo the SRAM size.
  assign offset  = ALU_res_in - 32'(BASE_ADDR);
  assign in_word = (SRAM_AW-1)'(offset >> 2);

  // Both enables high is treated as a read.
  assign is_load  = MEM_R_EN_in;
  assign is_store = MEM_W_EN_in & ~MEM_R_EN_in;
  assign mem_req  = is_load | is_store;

`ifdef MEM_WRITE_BUFFER_EN
  logic               buf_valid_q, buf_valid_d;
  logic [SRAM_AW-2:0] buf_word_q, buf_word_d;
  logic [31:0]        buf_data_q, buf_data_d;
  logic               capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_word_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_word_q  <= buf_word_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // A valid buffer entry owns the controller: it drains before any load
  // starts and is cleared in the drain's DONE cycle.
  always_comb begin
    capture     = is_store & ~buf_valid_q;
    buf_valid_d = buf_valid_q;
    buf_word_d  = buf_word_q;
    buf_data_d  = buf_data_q;
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_word_d  = in_word;
      buf_data_d  = Val_Rm_in;
    end else if (ctrl_done & buf_valid_q) begin
      buf_valid_d = 1'b0;
    end

    ctrl_start = ctrl_idle & (buf_valid_q | is_load);
    ctrl_we    = buf_valid_q;
    ctrl_word  = buf_valid_q ? buf_word_q : in_word;
    ctrl_wdata = buf_data_q;

    if (!mem_req)     ready = 1'b1;
    else if (is_load) ready = ctrl_done & ~buf_valid_q;
    else              ready = ~buf_valid_q;
  end
`else
  always_comb begin
    ctrl_start = ctrl_idle & mem_req;
    ctrl_we    = is_store;
    ctrl_word  = in_word;
    ctrl_wdata = Val_Rm_in;
    ready      = mem_req ? ctrl_done : 1'b1;
  end
`endif

  sram_ctrl #(
    .SRAM_AW     (SRAM_AW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_sram_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (ctrl_start),
    .we         (ctrl_we),
    .word_addr  (ctrl_word),
    .wdata      (ctrl_wdata),
    .rdata      (mem_out),
    .idle       (ctrl_idle),
    .done       (ctrl_done),
    .sram_addr  (sram_addr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_i  (sram_dq_i),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  assign ALU_res_out  = ALU_res_in;
  assign Dest_out     = Dest_in;
  assign WB_EN_out    = WB_EN_in & ready;
  assign MEM_R_EN_out = MEM_R_EN_in & ready;

  a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(MEM_R_EN_in && MEM_W_EN_in));

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed self-checking bench for mem_stage_sram with a behavioural SRAM model.
module tb_mem_stage_sram;

`ifdef MEM_WRITE_BUFFER_EN
  localparam int ST_STALL    = 0;
  localparam int LD_AFTER_ST = 9;
`else
  localparam int ST_STALL    = 4;
  localparam int LD_AFTER_ST = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_res_in, Val_Rm_in;
  logic [3:0]  Dest_in;
  logic        WB_EN_out, MEM_R_EN_out;
  logic [31:0] ALU_res_out, mem_out;
  logic [3:0]  Dest_out;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sram_mem [0:262143];

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk          (clk),
    .rst          (rst),
    .WB_EN_in     (WB_EN_in),
    .MEM_R_EN_in  (MEM_R_EN_in),
    .MEM_W_EN_in  (MEM_W_EN_in),
    .ALU_res_in   (ALU_res_in),
    .Val_Rm_in    (Val_Rm_in),
    .Dest_in      (Dest_in),
    .WB_EN_out    (WB_EN_out),
    .MEM_R_EN_out (MEM_R_EN_out),
    .ALU_res_out  (ALU_res_out),
    .mem_out      (mem_out),
    .Dest_out     (Dest_out),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_dq_o    (sram_dq_o),
    .sram_dq_i    (sram_dq_i),
    .sram_dq_oe   (sram_dq_oe),
    .sram_we_n    (sram_we_n)
  );

  // Async SRAM: combinational read, write while the strobe is low.
  assign sram_dq_i = sram_mem[sram_addr];
  always @(negedge clk) begin
    if (sram_dq_oe && !sram_we_n) sram_mem[sram_addr] = sram_dq_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction and wait (bounded) for ready; stall counts ready-low cycles.
  task automatic run_op(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic wb,
                        output int stall, output int we_low, output int leak,
                        output logic [17:0] first_addr);
    @(posedge clk); #1;
    MEM_R_EN_in = r;
    MEM_W_EN_in = w;
    ALU_res_in  = addr;
    Val_Rm_in   = data;
    WB_EN_in    = wb;
    Dest_in     = 4'd7;
    stall = 0; we_low = 0; leak = 0; first_addr = '0;
    @(negedge clk);
    while (ready !== 1'b1 && stall < 40) begin
      if (stall == 0) first_addr = sram_addr;
      if (sram_we_n === 1'b0) we_low++;
      if (WB_EN_out !== 1'b0 || MEM_R_EN_out !== 1'b0) leak++;
      stall++;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    MEM_R_EN_in = 1'b0;
    MEM_W_EN_in = 1'b0;
    WB_EN_in    = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int stall, we_low, leak;
    logic [17:0] fa;

    for (int i = 0; i < 262144; i++) sram_mem[i] = '0;
    sram_mem[18'h3FFFE] = 16'h1111;
    sram_mem[18'h3FFFF] = 16'h2222;

    rst = 1'b1;
    WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
    ALU_res_in = '0; Val_Rm_in = '0; Dest_in = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_out", mem_out, 32'h0);
    check("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    check("rst_oe", {31'h0, sram_dq_oe}, 32'h0);
    check("rst_addr", {14'h0, sram_addr}, 32'h0);
    check("rst_dq_o", {16'h0, sram_dq_o}, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: non-memory op passes through with no stall
    @(posedge clk); #1;
    ALU_res_in = 32'h55; WB_EN_in = 1'b1; Dest_in = 4'hA;
    @(negedge clk);
    check("alu_pass", ALU_res_out, 32'h55);
    check("alu_wb", {31'h0, WB_EN_out}, 32'h1);
    check("alu_ready", {31'h0, ready}, 32'h1);
    check("alu_we_n", {31'h0, sram_we_n}, 32'h1);
    check("alu_dest", {28'h0, Dest_out}, 32'hA);

    // 2: store 0xDEADBEEF to 1028 -> half-words 2 and 3
    run_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, stall, we_low, leak, fa);
    check("st_stall", stall, ST_STALL);
`ifndef MEM_WRITE_BUFFER_EN
    check("st_we_low", we_low, 2);
    check("st_addr", {14'h0, fa}, 32'h2);
`endif
    idle(8);
    check("st_mem_lo", {16'h0, sram_mem[2]}, 32'hBEEF);
    check("st_mem_hi", {16'h0, sram_mem[3]}, 32'hDEAD);

    // 3: load it back
    run_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, stall, we_low, leak, fa);
    check("ld_stall", stall, 4);
    check("ld_leak", leak, 0);
    check("ld_data", mem_out, 32'hDEADBEEF);
    check("ld_wb_done", {31'h0, WB_EN_out}, 32'h1);
    check("ld_rd_done", {31'h0, MEM_R_EN_out}, 32'h1);

    // 4: reset in the middle of a store to 1032; only the low half lands
    @(posedge clk); #1;
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b1; WB_EN_in = 1'b0;
    ALU_res_in = 32'd1032; Val_Rm_in = 32'h12345678;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    MEM_W_EN_in = 1'b0;
    @(negedge clk);
    check("mid_rst_we_n", {31'h0, sram_we_n}, 32'h1);
    check("mid_rst_ready", {31'h0, ready}, 32'h1);
    check("mid_rst_mem_out", mem_out, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("partial_hi_mem", {16'h0, sram_mem[5]}, 32'h0);
    run_op(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, stall, we_low, leak, fa);
    check("partial_ld_stall", stall, 4);
    check("partial_ld_data", mem_out, 32'h00005678);

    // 5: address below BASE_ADDR wraps to the top word
    run_op(1'b1, 1'b0, 32'd1020, 32'h0, 1'b1, stall, we_low, leak, fa);
    check("wrap_addr", {14'h0, fa}, 32'h3FFFE);
    check("wrap_stall", stall, 4);
    check("wrap_data", mem_out, 32'h22221111);

    // 6: store then immediate load of the same word
    run_op(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0, stall, we_low, leak, fa);
    check("bk_st_stall", stall, ST_STALL);
    run_op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, stall, we_low, leak, fa);
    check("bk_ld_stall", stall, LD_AFTER_ST);
    check("bk_ld_data", mem_out, 32'hCAFEF00D);
    check("bk_ld_wb", {31'h0, WB_EN_out}, 32'h1);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
